dbg_guv: RTL and testbench
==========================

DBG_GUV -- requirements
Module: dbg_guv

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, stream/command data width; minimum ADDR_WIDTH+36.
REQ-002 SHALL have parameter DEST_WIDTH, default 16, TDEST width.
REQ-003 SHALL have parameter ID_WIDTH, default 16, TID width.
REQ-004 SHALL have parameter CNT_SIZE, default 16, drop/log counter width.
REQ-005 SHALL have parameter ADDR_WIDTH, default 11, core address width.
REQ-006 SHALL have parameter ADDR, default 0, this core's address.
REQ-007 SHALL have parameter RESET_TYPE, default NO_RESET; kept for compatibility, no effect on reset behaviour.
REQ-008 SHALL have parameter STICKY_MODE, default 1; 1 means latch keeps shadow registers, 0 means latch clears them.
REQ-009 SHALL have parameter PIPE_STAGE, default 0; 1 means cmd_out is registered one cycle.
REQ-010 SHALL have port clk, input, 1 bit, sole clock, all logic on rising edge.
REQ-011 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-012 SHALL have cmd_in_TDATA in [DATA_WIDTH] and cmd_in_TVALID in [1]; command stream with no TREADY, never backpressured.
REQ-013 SHALL have cmd_out_TDATA out [DATA_WIDTH] and cmd_out_TVALID out [1]; daisy-chain to the next core.
REQ-014 SHALL have the in_ slave AXIS: TDATA [DATA_WIDTH], TVALID, TKEEP [DATA_WIDTH/8], TDEST [DEST_WIDTH], TID [ID_WIDTH] and TLAST as inputs; TREADY as output.
REQ-015 SHALL have the out_ master AXIS with the same fields as in_ and reversed directions.
REQ-016 SHALL have the log_catted_ master AXIS: TDATA out [DATA_WIDTH+DATA_WIDTH/8], TVALID out, TLAST out, TREADY in.

Function
REQ-017 SHALL decode each command into three fields:
- core address = TDATA[DATA_WIDTH-1 -: ADDR_WIDTH]
- reg = TDATA[DATA_WIDTH-ADDR_WIDTH-1 -: 4]
- value = TDATA[31:0]
REQ-018 SHALL accept a command when cmd_in_TVALID=1 and core address == ADDR; the shadow register is written on that edge.
REQ-019 SHALL forward non-matching commands unchanged on cmd_out; matching commands SHALL appear with cmd_out_TVALID=0.
REQ-020 SHALL make cmd_out combinational from cmd_in when PIPE_STAGE=0, and a 1-cycle register when PIPE_STAGE=1.
REQ-021 SHALL use this shadow register map; any other reg code is ignored:
- 0 drop_cnt
- 1 log_cnt
- 2 inj_TDATA, shifted: {inj_TDATA, value} truncated to DATA_WIDTH
- 3 inj_TKEEP
- 4 inj_TDEST
- 5 inj_TID
- 6 inj_TLAST
- 7 inj_TVALID
- 8 keep_pausing
- 9 keep_logging
- 10 keep_dropping
- 15 latch
REQ-022 SHALL, on latch, copy all shadow registers to live registers on the same edge; if STICKY_MODE=0 the shadows are then cleared to 0.
REQ-023 SHALL, when latch and a stream handshake hit the same edge, give the latch priority: live counters take the shadow values.
REQ-024 SHALL treat dropping as active when keep_dropping=1 or drop_cnt!=0, and logging as active when keep_logging=1 or log_cnt!=0.
REQ-025 SHALL use this priority order: inject > pause > normal.
REQ-026 Inject (live inj_TVALID=1):
- out carries the inj_ fields with out_TVALID=1 and in_TREADY=0.
- on an out handshake, inj_TVALID clears.
REQ-027 Pause (keep_pausing=1, no inject): in_TREADY=0, out_TVALID=0, log_catted_TVALID=0.
REQ-028 Normal forwarding:
- out = in.
- out_TVALID = in_TVALID & ~drop & (~log | log_catted_TREADY).
- log_catted_TVALID = in_TVALID & log & (drop | out_TREADY).
- in_TREADY = (drop | out_TREADY) & (~log | log_catted_TREADY).
REQ-029 SHALL drive log_catted_TDATA = {in_TKEEP, in_TDATA} and log_catted_TLAST = in_TLAST.
REQ-030 SHALL decrement drop_cnt and log_cnt by 1 on each in_ handshake while the respective counter is non-zero; they saturate at 0.
REQ-031 SHALL apply the counter rules with CNT_SIZE-bit unsigned arithmetic and no wrap.

Reset
REQ-032 SHALL, while rst=0, immediately clear all shadow and live registers and the PIPE_STAGE register to 0, making the core a transparent pass-through with cmd_out_TVALID=0 when registered.
REQ-033 SHALL abandon any in-progress inject, drop or log on reset mid-operation; no partial state survives.

Verification
REQ-034 No commands, in_TVALID=1, out_TREADY random -> out mirrors in, log_catted_TVALID=0, no flit lost or duplicated.
REQ-035 To ADDR=0, write reg 0 value 3 then latch (reg 15) -> exactly 3 in flits consumed and not output; on the next flit out_TVALID follows in_TVALID.
REQ-036 Write reg 1 value 2, latch, with random log_catted_TREADY -> 2 flits appear on both out and log with log TDATA {TKEEP, TDATA}, and no flit is lost.
REQ-037 Write reg 8 value 1, latch -> out_TVALID=0 and in_TREADY=0 until reg 8 is set to 0 and latched again.
REQ-038 Write reg 2 value 0xDEADBEEF twice, reg 7 value 1, latch -> one out flit with TDATA 0xDEADBEEFDEADBEEF, after which inj_TVALID=0.
REQ-039 Two-core chain (ADDR 0, 1), command addressed to core 1 -> core 0 unchanged and command forwarded; with PIPE_STAGE=1 it arrives one cycle later; rst=0 mid-drop -> counters cleared.

Source files
------------

// File: rtl/dbg_guv.sv
// Debug governor: per-core stream tap that can drop, log, pause or inject AXIS flits under daisy-chained command control.
// Latency: stream paths are combinational (0 cycles); cmd_out is 0 cycles, or 1 cycle when PIPE_STAGE=1.
// Backpressure: in_TREADY honours out_TREADY (unless dropping) and log_catted_TREADY (when logging); commands are never stalled.
module dbg_guv #(
    parameter int DATA_WIDTH  = 64,
    parameter int DEST_WIDTH  = 16,
    parameter int ID_WIDTH    = 16,
    parameter int CNT_SIZE    = 16,
    parameter int ADDR_WIDTH  = 11,
    parameter int ADDR        = 0,
    parameter     RESET_TYPE  = "NO_RESET",
    parameter int STICKY_MODE = 1,
    parameter int PIPE_STAGE  = 0
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic [DATA_WIDTH-1:0]        cmd_in_TDATA,
    input  logic                         cmd_in_TVALID,
    output logic [DATA_WIDTH-1:0]        cmd_out_TDATA,
    output logic                         cmd_out_TVALID,

    input  logic [DATA_WIDTH-1:0]        in_TDATA,
    input  logic                         in_TVALID,
    output logic                         in_TREADY,
    input  logic [DATA_WIDTH/8-1:0]      in_TKEEP,
    input  logic [DEST_WIDTH-1:0]        in_TDEST,
    input  logic [ID_WIDTH-1:0]          in_TID,
    input  logic                         in_TLAST,

    output logic [DATA_WIDTH-1:0]        out_TDATA,
    output logic                         out_TVALID,
    input  logic                         out_TREADY,
    output logic [DATA_WIDTH/8-1:0]      out_TKEEP,
    output logic [DEST_WIDTH-1:0]        out_TDEST,
    output logic [ID_WIDTH-1:0]          out_TID,
    output logic                         out_TLAST,

    output logic [DATA_WIDTH+DATA_WIDTH/8-1:0] log_catted_TDATA,
    output logic                         log_catted_TVALID,
    output logic                         log_catted_TLAST,
    input  logic                         log_catted_TREADY
);
    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] MY_ADDR = ADDR[ADDR_WIDTH-1:0];

    // RESET_TYPE only exists so older instantiations still elaborate.
    logic unused_reset_type;
    assign unused_reset_type = (RESET_TYPE == "NO_RESET");

    // One register image; the shadow copy is written by commands, the live copy steers the stream.
    typedef struct packed {
        logic [CNT_SIZE-1:0]   drop_cnt;
        logic [CNT_SIZE-1:0]   log_cnt;
        logic [DATA_WIDTH-1:0] inj_tdata;
        logic [KEEP_W-1:0]     inj_tkeep;
        logic [DEST_WIDTH-1:0] inj_tdest;
        logic [ID_WIDTH-1:0]   inj_tid;
        logic                  inj_tlast;
        logic                  inj_tvalid;
        logic                  keep_pausing;
        logic                  keep_logging;
        logic                  keep_dropping;
    } dbg_regs_t;

    dbg_regs_t shadow_q, shadow_d;
    dbg_regs_t live_q, live_d;

    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [3:0]            cmd_reg;
    logic [31:0]           cmd_val;
    logic                  cmd_hit;

    assign cmd_addr = cmd_in_TDATA[DATA_WIDTH-1 -: ADDR_WIDTH];
    assign cmd_reg  = cmd_in_TDATA[DATA_WIDTH-ADDR_WIDTH-1 -: 4];
    assign cmd_val  = cmd_in_TDATA[31:0];
    assign cmd_hit  = cmd_in_TVALID && (cmd_addr == MY_ADDR);

    logic inject, pause, dropping, logging, in_hs;

    assign inject   = live_q.inj_tvalid;
    assign pause    = live_q.keep_pausing && !inject;
    assign dropping = live_q.keep_dropping || (live_q.drop_cnt != '0);
    assign logging  = live_q.keep_logging  || (live_q.log_cnt  != '0);
    assign in_hs    = in_TVALID && in_TREADY;

    // Stream steering: inject beats pause, pause beats normal forwarding.
    always_comb begin
        out_TDATA         = in_TDATA;
        out_TKEEP         = in_TKEEP;
        out_TDEST         = in_TDEST;
        out_TID           = in_TID;
        out_TLAST         = in_TLAST;
        out_TVALID        = 1'b0;
        in_TREADY         = 1'b0;
        log_catted_TVALID = 1'b0;
        if (inject) begin
            out_TDATA  = live_q.inj_tdata;
            out_TKEEP  = live_q.inj_tkeep;
            out_TDEST  = live_q.inj_tdest;
            out_TID    = live_q.inj_tid;
            out_TLAST  = live_q.inj_tlast;
            out_TVALID = 1'b1;
        end else if (!pause) begin
            out_TVALID        = in_TVALID && !dropping && (!logging || log_catted_TREADY);
            log_catted_TVALID = in_TVALID && logging && (dropping || out_TREADY);
            in_TREADY         = (dropping || out_TREADY) && (!logging || log_catted_TREADY);
        end
    end

    assign log_catted_TDATA = {in_TKEEP, in_TDATA};
    assign log_catted_TLAST = in_TLAST;

    // Next-state for shadow and live registers; a latch overrides any same-edge counter or inject update.
    always_comb begin
        shadow_d = shadow_q;
        live_d   = live_q;

        if (in_hs && live_q.drop_cnt != '0) live_d.drop_cnt = live_q.drop_cnt - CNT_SIZE'(1);
        if (in_hs && live_q.log_cnt  != '0) live_d.log_cnt  = live_q.log_cnt  - CNT_SIZE'(1);
        if (inject && out_TREADY)           live_d.inj_tvalid = 1'b0;

        if (cmd_hit) begin
            case (cmd_reg)
                4'd0:  shadow_d.drop_cnt      = CNT_SIZE'(cmd_val);
                4'd1:  shadow_d.log_cnt       = CNT_SIZE'(cmd_val);
                4'd2:  shadow_d.inj_tdata     = {shadow_q.inj_tdata[DATA_WIDTH-33:0], cmd_val};
                4'd3:  shadow_d.inj_tkeep     = KEEP_W'(cmd_val);
                4'd4:  shadow_d.inj_tdest     = DEST_WIDTH'(cmd_val);
                4'd5:  shadow_d.inj_tid       = ID_WIDTH'(cmd_val);
                4'd6:  shadow_d.inj_tlast     = cmd_val[0];
                4'd7:  shadow_d.inj_tvalid    = cmd_val[0];
                4'd8:  shadow_d.keep_pausing  = cmd_val[0];
                4'd9:  shadow_d.keep_logging  = cmd_val[0];
                4'd10: shadow_d.keep_dropping = cmd_val[0];
                4'd15: begin
                    live_d = shadow_q;
                    if (STICKY_MODE == 0) shadow_d = '0;
                end
                default: ;
            endcase
        end
    end

    // Register image state; reset returns the core to plain pass-through.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q <= '0;
            live_q   <= '0;
        end else begin
            shadow_q <= shadow_d;
            live_q   <= live_d;
        end
    end

    generate
        if (PIPE_STAGE != 0) begin : g_cmd_pipe
            logic [DATA_WIDTH-1:0] cmd_tdata_q, cmd_tdata_d;
            logic                  cmd_tvalid_q, cmd_tvalid_d;

            // Commands for this core are swallowed; everything else moves one hop down the chain.
            always_comb begin
                cmd_tdata_d  = cmd_in_TDATA;
                cmd_tvalid_d = cmd_in_TVALID && !cmd_hit;
            end

            // One-cycle command retiming stage.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cmd_tdata_q  <= '0;
                    cmd_tvalid_q <= 1'b0;
                end else begin
                    cmd_tdata_q  <= cmd_tdata_d;
                    cmd_tvalid_q <= cmd_tvalid_d;
                end
            end

            assign cmd_out_TDATA  = cmd_tdata_q;
            assign cmd_out_TVALID = cmd_tvalid_q;
        end else begin : g_cmd_comb
            assign cmd_out_TDATA  = cmd_in_TDATA;
            assign cmd_out_TVALID = cmd_in_TVALID && !cmd_hit;
        end
    endgenerate
endmodule

// File: tb/tb_dbg_guv.sv
// Bench for dbg_guv: core 0 (comb command path) feeds core 1 (registered command path).
// Core 0 stream is scored against a queue model; core 1 is probed for chain and reset behaviour.
// Readies are randomised per cycle where the scenario allows it.
module tb_dbg_guv;
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic [15:0] dest;
        logic [15:0] id;
        logic        last;
    } flit_t;

    logic clk, rst;
    logic [63:0] cmd_in_TDATA, c0_cmd_dat, c1_cmd_dat;
    logic        cmd_in_TVALID, c0_cmd_vld, c1_cmd_vld;

    logic [63:0] in_TDATA, out_TDATA;
    logic [7:0]  in_TKEEP, out_TKEEP;
    logic [15:0] in_TDEST, in_TID, out_TDEST, out_TID;
    logic        in_TVALID, in_TREADY, in_TLAST, out_TVALID, out_TREADY, out_TLAST;
    logic [71:0] log_TDATA;
    logic        log_TVALID, log_TLAST, log_TREADY;

    logic [63:0] c1_in_TDATA, c1_out_TDATA;
    logic [7:0]  c1_in_TKEEP, c1_out_TKEEP;
    logic [15:0] c1_in_TDEST, c1_in_TID, c1_out_TDEST, c1_out_TID;
    logic        c1_in_TVALID, c1_in_TREADY, c1_in_TLAST, c1_out_TVALID, c1_out_TLAST;
    logic [71:0] c1_log_TDATA;
    logic        c1_log_TVALID, c1_log_TLAST;

    dbg_guv #(.ADDR(0), .PIPE_STAGE(0)) u0 (
        .clk(clk), .rst(rst),
        .cmd_in_TDATA(cmd_in_TDATA), .cmd_in_TVALID(cmd_in_TVALID),
        .cmd_out_TDATA(c0_cmd_dat), .cmd_out_TVALID(c0_cmd_vld),
        .in_TDATA(in_TDATA), .in_TVALID(in_TVALID), .in_TREADY(in_TREADY), .in_TKEEP(in_TKEEP),
        .in_TDEST(in_TDEST), .in_TID(in_TID), .in_TLAST(in_TLAST),
        .out_TDATA(out_TDATA), .out_TVALID(out_TVALID), .out_TREADY(out_TREADY), .out_TKEEP(out_TKEEP),
        .out_TDEST(out_TDEST), .out_TID(out_TID), .out_TLAST(out_TLAST),
        .log_catted_TDATA(log_TDATA), .log_catted_TVALID(log_TVALID),
        .log_catted_TLAST(log_TLAST), .log_catted_TREADY(log_TREADY)
    );

    dbg_guv #(.ADDR(1), .PIPE_STAGE(1)) u1 (
        .clk(clk), .rst(rst),
        .cmd_in_TDATA(c0_cmd_dat), .cmd_in_TVALID(c0_cmd_vld),
        .cmd_out_TDATA(c1_cmd_dat), .cmd_out_TVALID(c1_cmd_vld),
        .in_TDATA(c1_in_TDATA), .in_TVALID(c1_in_TVALID), .in_TREADY(c1_in_TREADY), .in_TKEEP(c1_in_TKEEP),
        .in_TDEST(c1_in_TDEST), .in_TID(c1_in_TID), .in_TLAST(c1_in_TLAST),
        .out_TDATA(c1_out_TDATA), .out_TVALID(c1_out_TVALID), .out_TREADY(1'b1), .out_TKEEP(c1_out_TKEEP),
        .out_TDEST(c1_out_TDEST), .out_TID(c1_out_TID), .out_TLAST(c1_out_TLAST),
        .log_catted_TDATA(c1_log_TDATA), .log_catted_TVALID(c1_log_TVALID),
        .log_catted_TLAST(c1_log_TLAST), .log_catted_TREADY(1'b1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard and reference model of core 0's register image.
    flit_t       out_q[$];
    flit_t       log_q[$];
    logic [15:0] m_sh_drop, m_sh_log, m_drop, m_log;
    logic [63:0] m_sh_injd;
    logic        m_sh_inj, m_sh_pause, m_pause, m_inj;
    logic        in_fire, stream_en, rdy_rand;
    int          seq, n_swallowed, n_log_fires;

    task automatic model_reset();
        m_sh_drop = '0; m_sh_log = '0; m_drop = '0; m_log = '0;
        m_sh_injd = '0; m_sh_inj = 1'b0; m_sh_pause = 1'b0; m_pause = 1'b0; m_inj = 1'b0;
    endtask

    // Monitor: sample at the falling edge what will commit on the next rising edge.
    initial begin : mon
        flit_t f, e;
        logic  out_fire, log_fire;
        forever begin
            @(negedge clk);
            in_fire  = in_TVALID && in_TREADY;
            out_fire = out_TVALID && out_TREADY;
            log_fire = log_TVALID && log_TREADY;
            if (m_pause && !m_inj) begin
                chk("pause_in_rdy", 128'(in_TREADY), 128'(0));
                chk("pause_out_vld", 128'(out_TVALID), 128'(0));
                chk("pause_log_vld", 128'(log_TVALID), 128'(0));
            end else if (!m_inj && m_drop == 0 && m_log == 0 && in_TVALID) begin
                chk("fwd_out_vld", 128'(out_TVALID), 128'(1));
                chk("fwd_in_rdy", 128'(in_TREADY), 128'(out_TREADY));
                chk("fwd_log_vld", 128'(log_TVALID), 128'(0));
            end
            if (in_fire && !out_fire) n_swallowed++;
            if (in_fire) begin
                f = '{in_TDATA, in_TKEEP, in_TDEST, in_TID, in_TLAST};
                if (m_log != 0) begin log_q.push_back(f); m_log--; end
                if (m_drop != 0) m_drop--;
                else out_q.push_back(f);
            end
            if (out_fire) begin
                if (out_q.size() == 0) chk("out_extra", 128'(1), 128'(0));
                else begin
                    e = out_q.pop_front();
                    f = '{out_TDATA, out_TKEEP, out_TDEST, out_TID, out_TLAST};
                    chk("out_flit", 128'(f), 128'(e));
                end
                m_inj = 1'b0;
            end
            if (log_fire) begin
                n_log_fires++;
                if (log_q.size() == 0) chk("log_extra", 128'(1), 128'(0));
                else begin
                    e = log_q.pop_front();
                    chk("log_flit", 128'({log_TDATA, log_TLAST}), 128'({e.keep, e.data, e.last}));
                end
            end
            if (cmd_in_TVALID && cmd_in_TDATA[63:53] == 11'd0) begin
                case (cmd_in_TDATA[52:49])
                    4'd0:  m_sh_drop  = cmd_in_TDATA[15:0];
                    4'd1:  m_sh_log   = cmd_in_TDATA[15:0];
                    4'd2:  m_sh_injd  = {m_sh_injd[31:0], cmd_in_TDATA[31:0]};
                    4'd7:  m_sh_inj   = cmd_in_TDATA[0];
                    4'd8:  m_sh_pause = cmd_in_TDATA[0];
                    4'd15: begin
                        m_drop  = m_sh_drop;
                        m_log   = m_sh_log;
                        m_pause = m_sh_pause;
                        m_inj   = m_sh_inj;
                        if (m_sh_inj) out_q.push_back('{m_sh_injd, 8'h0, 16'h0, 16'h0, 1'b0});
                    end
                    default: ;
                endcase
            end
        end
    end

    // Stream driver: change inputs just after the rising edge, hold a flit until it is accepted.
    initial begin : drv
        forever begin
            @(posedge clk);
            #1;
            if (in_TVALID && in_fire) in_TVALID = 1'b0;
            if (!in_TVALID && stream_en) begin
                seq++;
                in_TDATA  = {$urandom, seq};
                in_TKEEP  = 8'($urandom);
                in_TDEST  = 16'($urandom);
                in_TID    = 16'($urandom);
                in_TLAST  = seq[0];
                in_TVALID = 1'b1;
            end
            out_TREADY = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            log_TREADY = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_cmd(input int a, input int r, input logic [31:0] v);
        logic [10:0] aa;
        logic [3:0]  rr;
        aa = a[10:0];
        rr = r[3:0];
        @(posedge clk);
        #1;
        cmd_in_TDATA  = {aa, rr, 17'h0, v};
        cmd_in_TVALID = 1'b1;
        @(posedge clk);
        #1;
        cmd_in_TVALID = 1'b0;
    endtask

    task automatic drain(input string tag);
        stream_en = 1'b0;
        for (int t = 0; t < 400 && (in_TVALID || out_q.size() != 0 || log_q.size() != 0); t++)
            @(posedge clk);
        repeat (2) @(posedge clk);
        chk({tag, "_in_idle"}, 128'(in_TVALID), 128'(0));
        chk({tag, "_out_q"}, 128'(out_q.size()), 128'(0));
        chk({tag, "_log_q"}, 128'(log_q.size()), 128'(0));
    endtask

    initial begin : main
        logic [63:0] c;
        rst = 1'b0; cmd_in_TDATA = '0; cmd_in_TVALID = 1'b0;
        in_TDATA = '0; in_TVALID = 1'b0; in_TKEEP = '0; in_TDEST = '0; in_TID = '0; in_TLAST = 1'b0;
        out_TREADY = 1'b1; log_TREADY = 1'b1;
        c1_in_TDATA = 64'h0123_4567_89AB_CDEF; c1_in_TVALID = 1'b1; c1_in_TKEEP = 8'hA5;
        c1_in_TDEST = 16'h1111; c1_in_TID = 16'h2222; c1_in_TLAST = 1'b1;
        in_fire = 1'b0; stream_en = 1'b0; rdy_rand = 1'b0; seq = 0; n_swallowed = 0; n_log_fires = 0;
        model_reset();

        repeat (2) @(negedge clk);
        chk("rst_out_vld", 128'(out_TVALID), 128'(0));
        chk("rst_in_rdy", 128'(in_TREADY), 128'(1));
        chk("rst_log_vld", 128'(log_TVALID), 128'(0));
        chk("rst_c0_cmd_vld", 128'(c0_cmd_vld), 128'(0));
        chk("rst_c1_cmd_vld", 128'(c1_cmd_vld), 128'(0));
        @(posedge clk); #2; rst = 1'b1;

        // Plain forwarding with a jittery sink.
        rdy_rand = 1'b1; stream_en = 1'b1;
        repeat (60) @(posedge clk);
        drain("fwd");

        // Drop three flits.
        rdy_rand = 1'b0; n_swallowed = 0; stream_en = 1'b1;
        send_cmd(0, 0, 32'd3);
        send_cmd(0, 15, 32'd0);
        repeat (20) @(posedge clk);
        drain("drop");
        chk("drop_count", 128'(n_swallowed), 128'(3));

        // Log two flits while both sinks jitter.
        rdy_rand = 1'b1; n_log_fires = 0; stream_en = 1'b1;
        send_cmd(0, 1, 32'd2);
        send_cmd(0, 15, 32'd0);
        repeat (40) @(posedge clk);
        drain("log");
        chk("log_count", 128'(n_log_fires), 128'(2));

        // Pause, then release.
        rdy_rand = 1'b0; stream_en = 1'b1;
        send_cmd(0, 8, 32'd1);
        send_cmd(0, 15, 32'd0);
        repeat (12) @(posedge clk);
        send_cmd(0, 8, 32'd0);
        send_cmd(0, 15, 32'd0);
        repeat (10) @(posedge clk);
        drain("pause");

        // Inject one flit built from two data writes.
        send_cmd(0, 2, 32'hDEADBEEF);
        send_cmd(0, 2, 32'hDEADBEEF);
        send_cmd(0, 7, 32'd1);
        send_cmd(0, 15, 32'd0);
        drain("inj");
        repeat (2) @(negedge clk);
        chk("inj_cleared", 128'(out_TVALID), 128'(0));

        // Chain: command for core 1 passes core 0 and is consumed by core 1.
        c = {11'd1, 4'd8, 17'h0, 32'd1};
        @(posedge clk); #1; cmd_in_TDATA = c; cmd_in_TVALID = 1'b1;
        @(negedge clk);
        chk("chain_c0_fwd_vld", 128'(c0_cmd_vld), 128'(1));
        chk("chain_c0_fwd_dat", 128'(c0_cmd_dat), 128'(c));
        @(posedge clk); #1; cmd_in_TVALID = 1'b0;
        @(negedge clk);
        chk("chain_c1_consumed", 128'(c1_cmd_vld), 128'(0));
        send_cmd(1, 15, 32'd0);
        @(negedge clk);
        chk("chain_c1_paused", 128'(c1_in_TREADY), 128'(0));
        chk("chain_c1_out_vld", 128'(c1_out_TVALID), 128'(0));
        chk("chain_c0_unpaused", 128'(in_TREADY), 128'(1));
        // Command for core 2 leaves core 1 one cycle later.
        c = {11'd2, 4'd3, 17'h0, 32'h55};
        @(posedge clk); #1; cmd_in_TDATA = c; cmd_in_TVALID = 1'b1;
        @(negedge clk);
        chk("pipe_t0_vld", 128'(c1_cmd_vld), 128'(0));
        @(posedge clk); #1; cmd_in_TVALID = 1'b0;
        @(negedge clk);
        chk("pipe_t1_vld", 128'(c1_cmd_vld), 128'(1));
        chk("pipe_t1_dat", 128'(c1_cmd_dat), 128'(c));
        @(negedge clk);
        chk("pipe_t2_vld", 128'(c1_cmd_vld), 128'(0));

        // Reset in the middle of a long drop.
        stream_en = 1'b1;
        send_cmd(0, 7, 32'd0);
        send_cmd(0, 0, 32'd20);
        send_cmd(0, 15, 32'd0);
        repeat (5) @(posedge clk);
        #2; rst = 1'b0; model_reset();
        #1;
        chk("rstmid_out_vld", 128'(out_TVALID), 128'(in_TVALID));
        chk("rstmid_in_rdy", 128'(in_TREADY), 128'(1));
        chk("rstmid_c1_rdy", 128'(c1_in_TREADY), 128'(1));
        chk("rstmid_c1_pass", 128'({c1_out_TVALID, c1_out_TDATA, c1_out_TKEEP, c1_out_TLAST}),
            128'({c1_in_TVALID, c1_in_TDATA, c1_in_TKEEP, c1_in_TLAST}));
        chk("rstmid_c1_ids", 128'({c1_out_TDEST, c1_out_TID}), 128'({c1_in_TDEST, c1_in_TID}));
        chk("rstmid_c1_log", 128'({c1_log_TVALID, c1_log_TDATA, c1_log_TLAST}),
            128'({1'b0, c1_in_TKEEP, c1_in_TDATA, c1_in_TLAST}));
        repeat (2) @(posedge clk);
        #2; rst = 1'b1; n_swallowed = 0;
        repeat (10) @(posedge clk);
        drain("rstmid");
        chk("post_rst_no_drop", 128'(n_swallowed), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
